// File: rtl/ascon_pkg.sv
// Types, constants and helpers shared by the ASCON-128 encrypt and decrypt cores.
package ascon_pkg;

   typedef logic [4:0][63:0] t_state_array;

   localparam logic [63:0] ASCON_IV   = 64'h80400c0600000000;
   localparam logic [3:0]  LAST_ROUND = 4'd11;
   localparam logic [3:0]  P6_FIRST   = 4'd6;

   typedef enum logic [2:0] {
      IDLE,
      INIT,
      WAIT_AD,
      AD,
      WAIT_CT,
      CT,
      FINAL
   } t_dec_state;

   function automatic logic [7:0] round_const(input logic [3:0] idx);
      return {4'hF - idx, idx};
   endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational ASCON permutation round: constant addition, bitsliced
// S-box and linear diffusion. Word k of the state lives in bits [64k+63:64k].
module ascon_round
   import ascon_pkg::*;
(
   input  logic [319:0] state_in,
   input  logic [3:0]   round_idx,
   output logic [319:0] state_out
);

   logic [63:0] x0, x1, x2, x3, x4;
   logic [63:0] a0, a2, a4;
   logic [63:0] b0, b1, b2, b3, b4;
   logic [63:0] c0, c1, c2, c3, c4;

   assign x0 = state_in[63:0];
   assign x1 = state_in[127:64];
   assign x2 = state_in[191:128] ^ {56'd0, round_const(round_idx)};
   assign x3 = state_in[255:192];
   assign x4 = state_in[319:256];

   // S-box input mixing, chi-like nonlinear step, then output mixing
   assign a0 = x0 ^ x4;
   assign a2 = x2 ^ x1;
   assign a4 = x4 ^ x3;

   assign b0 = a0 ^ (~x1 & a2);
   assign b1 = x1 ^ (~a2 & x3);
   assign b2 = a2 ^ (~x3 & a4);
   assign b3 = x3 ^ (~a4 & a0);
   assign b4 = a4 ^ (~a0 & x1);

   assign c0 = b0 ^ b4;
   assign c1 = b1 ^ b0;
   assign c2 = ~b2;
   assign c3 = b3 ^ b2;
   assign c4 = b4;

   // Linear layer: each word XORed with two right-rotations of itself
   assign state_out[63:0]    = c0 ^ {c0[18:0], c0[63:19]} ^ {c0[27:0], c0[63:28]};
   assign state_out[127:64]  = c1 ^ {c1[60:0], c1[63:61]} ^ {c1[38:0], c1[63:39]};
   assign state_out[191:128] = c2 ^ {c2[0],    c2[63:1]}  ^ {c2[5:0],  c2[63:6]};
   assign state_out[255:192] = c3 ^ {c3[9:0],  c3[63:10]} ^ {c3[16:0], c3[63:17]};
   assign state_out[319:256] = c4 ^ {c4[6:0],  c4[63:7]}  ^ {c4[40:0], c4[63:41]};

endmodule

// File: rtl/ascon_decrypt.sv
// ASCON-128 decryption core: one round per enabled clock, plaintext released per
// block before authentication, tag verdict registered as FINAL completes.
module ascon_decrypt
   import ascon_pkg::*;
#(
   parameter int NUM_CT_BLOCKS = 3
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         i_sys_enable,
   input  logic         i_start,
   input  logic         i_data_valid,
   input  logic [63:0]  i_data,
   input  logic [3:0]   i_last_bytes,
   input  logic [127:0] i_key,
   input  logic [127:0] i_nonce,
   input  logic [127:0] i_tag,
   output logic         o_ready,
   output logic [63:0]  o_plain,
   output logic         o_valid_plain,
   output logic         o_tag_ok,
   output logic         o_done
);

   localparam logic [1:0]  LAST_BLK = 2'(NUM_CT_BLOCKS - 1);
   localparam logic [63:0] MSB_PAD  = 64'h8000_0000_0000_0000;

   t_dec_state   state_q, state_d;
   t_state_array s_q, s_d, round_out;
   logic [3:0]   rnd_q, rnd_d;
   logic [1:0]   blk_q, blk_d;
   logic [3:0]   last_bytes_q, last_bytes_d;
   logic [63:0]  plain_q, plain_d;
   logic         valid_plain_q, valid_plain_d;
   logic         tag_ok_q, tag_ok_d;
   logic         done_q, done_d;

   logic         final_blk;
   logic [3:0]   n_bytes;
   logic [63:0]  keep_mask;
   logic [63:0]  pad;
   logic [127:0] tag_calc;

   ascon_round u_round (
      .state_in  (s_q),
      .round_idx (rnd_q),
      .state_out (round_out)
   );

   assign final_blk = (blk_q == LAST_BLK);
   assign n_bytes   = final_blk ? last_bytes_q : 4'd8;
   // Ones over the top n_bytes bytes; a shift of 64 leaves the full word selected
   assign keep_mask = ~({64{1'b1}} >> {n_bytes, 3'b000});
   assign pad       = (n_bytes == 4'd8) ? MSB_PAD : (MSB_PAD >> {n_bytes, 3'b000});
   assign tag_calc  = {round_out[3], round_out[4]} ^ i_key;

   assign o_ready       = (state_q == WAIT_AD) || (state_q == WAIT_CT);
   assign o_plain       = plain_q;
   assign o_valid_plain = valid_plain_q;
   assign o_tag_ok      = tag_ok_q;
   assign o_done        = done_q;

   always_comb begin
      state_d       = state_q;
      s_d           = s_q;
      rnd_d         = rnd_q;
      blk_d         = blk_q;
      last_bytes_d  = last_bytes_q;
      plain_d       = plain_q;
      valid_plain_d = 1'b0;
      tag_ok_d      = tag_ok_q;
      done_d        = 1'b0;

      case (state_q)
         IDLE: begin
            if (i_start) begin
               s_d[0]       = ASCON_IV;
               s_d[1]       = i_key[127:64];
               s_d[2]       = i_key[63:0];
               s_d[3]       = i_nonce[127:64];
               s_d[4]       = i_nonce[63:0];
               rnd_d        = 4'd0;
               blk_d        = 2'd0;
               tag_ok_d     = 1'b0;
               last_bytes_d = i_last_bytes;
               state_d      = INIT;
            end
         end
         INIT: begin
            s_d   = round_out;
            rnd_d = rnd_q + 4'd1;
            if (rnd_q == LAST_ROUND) begin
               s_d[3]  = round_out[3] ^ i_key[127:64];
               s_d[4]  = round_out[4] ^ i_key[63:0];
               state_d = WAIT_AD;
            end
         end
         WAIT_AD: begin
            if (i_data_valid) begin
               s_d[0]  = s_q[0] ^ i_data;
               rnd_d   = P6_FIRST;
               state_d = AD;
            end
         end
         AD: begin
            s_d   = round_out;
            rnd_d = rnd_q + 4'd1;
            if (rnd_q == LAST_ROUND) begin
               s_d[4]  = round_out[4] ^ 64'd1;
               state_d = WAIT_CT;
            end
         end
         WAIT_CT: begin
            if (i_data_valid) begin
               plain_d       = (s_q[0] ^ i_data) & keep_mask;
               valid_plain_d = 1'b1;
               s_d[0]        = (i_data & keep_mask) | (s_q[0] & ~keep_mask);
               if (final_blk) begin
                  s_d[0]  = ((i_data & keep_mask) | (s_q[0] & ~keep_mask)) ^ pad;
                  s_d[1]  = s_q[1] ^ i_key[127:64];
                  s_d[2]  = s_q[2] ^ i_key[63:0];
                  rnd_d   = 4'd0;
                  state_d = FINAL;
               end else begin
                  blk_d   = blk_q + 2'd1;
                  rnd_d   = P6_FIRST;
                  state_d = CT;
               end
            end
         end
         CT: begin
            s_d   = round_out;
            rnd_d = rnd_q + 4'd1;
            if (rnd_q == LAST_ROUND) begin
               state_d = WAIT_CT;
            end
         end
         FINAL: begin
            s_d   = round_out;
            rnd_d = rnd_q + 4'd1;
            if (rnd_q == LAST_ROUND) begin
               tag_ok_d = (tag_calc == i_tag);
               done_d   = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // A low enable freezes everything, so single-cycle pulses stretch with it
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         s_q           <= '0;
         rnd_q         <= 4'd0;
         blk_q         <= 2'd0;
         last_bytes_q  <= 4'd0;
         plain_q       <= 64'd0;
         valid_plain_q <= 1'b0;
         tag_ok_q      <= 1'b0;
         done_q        <= 1'b0;
      end else if (i_sys_enable) begin
         state_q       <= state_d;
         s_q           <= s_d;
         rnd_q         <= rnd_d;
         blk_q         <= blk_d;
         last_bytes_q  <= last_bytes_d;
         plain_q       <= plain_d;
         valid_plain_q <= valid_plain_d;
         tag_ok_q      <= tag_ok_d;
         done_q        <= done_d;
      end
   end

endmodule

// File: tb/tb_ascon_decrypt.sv
// Randomised bench for ascon_decrypt: a word-level ASCON encryptor model produces
// ciphertext and tag, the DUT must return the plaintext and the tag verdict.
module tb_ascon_decrypt;

   localparam int NB = 3;
   localparam logic [63:0] IV = 64'h80400c0600000000;
   localparam logic [4:0] SBOX [32] = '{
      5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
      5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
      5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
      5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
   localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
   localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

   logic         clock;
   logic         reset;
   logic         i_sys_enable;
   logic         i_start;
   logic         i_data_valid;
   logic [63:0]  i_data;
   logic [3:0]   i_last_bytes;
   logic [127:0] i_key;
   logic [127:0] i_nonce;
   logic [127:0] i_tag;
   logic         o_ready;
   logic [63:0]  o_plain;
   logic         o_valid_plain;
   logic         o_tag_ok;
   logic         o_done;

   int total = 0;
   int bad   = 0;

   logic [63:0]  ms [5];
   logic [63:0]  pt_blk [NB];
   logic [63:0]  ct_blk [NB];
   logic [63:0]  exp_pt [NB];
   logic [127:0] exp_tag;

   ascon_decrypt #(.NUM_CT_BLOCKS(NB)) dut (
      .clock         (clock),
      .reset         (reset),
      .i_sys_enable  (i_sys_enable),
      .i_start       (i_start),
      .i_data_valid  (i_data_valid),
      .i_data        (i_data),
      .i_last_bytes  (i_last_bytes),
      .i_key         (i_key),
      .i_nonce       (i_nonce),
      .i_tag         (i_tag),
      .o_ready       (o_ready),
      .o_plain       (o_plain),
      .o_valid_plain (o_valid_plain),
      .o_tag_ok      (o_tag_ok),
      .o_done        (o_done)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
      return (v >> n) | (v << (64 - n));
   endfunction

   // Permutation rounds first..11, S-box applied column by column via table
   task automatic model_perm(input int first);
      logic [4:0] col;
      logic [4:0] sub;
      for (int r = first; r < 12; r++) begin
         ms[2] = ms[2] ^ 64'((15 - r) * 16 + r);
         for (int b = 0; b < 64; b++) begin
            col = {ms[0][b], ms[1][b], ms[2][b], ms[3][b], ms[4][b]};
            sub = SBOX[col];
            ms[0][b] = sub[4];
            ms[1][b] = sub[3];
            ms[2][b] = sub[2];
            ms[3][b] = sub[1];
            ms[4][b] = sub[0];
         end
         for (int w = 0; w < 5; w++)
            ms[w] = ms[w] ^ rotr(ms[w], ROT_A[w]) ^ rotr(ms[w], ROT_B[w]);
      end
   endtask

   task automatic model_encrypt(input logic [127:0] k, input logic [127:0] n,
                                input logic [63:0] ad, input int lb);
      logic [63:0] ones;
      logic [63:0] mask;
      logic [63:0] c;
      ones  = '1;
      ms[0] = IV;
      ms[1] = k[127:64];
      ms[2] = k[63:0];
      ms[3] = n[127:64];
      ms[4] = n[63:0];
      model_perm(0);
      ms[3] = ms[3] ^ k[127:64];
      ms[4] = ms[4] ^ k[63:0];
      ms[0] = ms[0] ^ ad;
      model_perm(6);
      ms[4] = ms[4] ^ 64'd1;
      for (int j = 0; j < NB; j++) begin
         mask = (j == NB - 1 && lb < 8) ? ~(ones >> (8 * lb)) : ones;
         c = (ms[0] ^ pt_blk[j]) & mask;
         ct_blk[j] = c | ({$urandom, $urandom} & ~mask);
         exp_pt[j] = pt_blk[j] & mask;
         ms[0] = c | (ms[0] & ~mask);
         if (j < NB - 1) begin
            model_perm(6);
         end else begin
            ms[0] = ms[0] ^ ((lb == 8) ? 64'h8000_0000_0000_0000 : (64'h80 << (8 * (7 - lb))));
            ms[1] = ms[1] ^ k[127:64];
            ms[2] = ms[2] ^ k[63:0];
            model_perm(0);
            exp_tag = {ms[3], ms[4]} ^ k;
         end
      end
   endtask

   // mode: 0 plain, 1 enable freezes, 2 ignored start/valid noise, 3 reset in FINAL
   task automatic run_msg(input string name, input logic [127:0] k, input logic [127:0] n,
                          input logic [63:0] ad, input int lb, input logic [127:0] tag_in,
                          input bit exp_ok, input int exp_lat, input int mode, input bit gaps);
      int e, blk_in, pt_seen, dis_cnt, trig_ct;
      bit done_seen, aborted, prev_en, xfer, freeze_pv, en;
      @(negedge clock);
      i_key = k; i_nonce = n; i_last_bytes = 4'(lb); i_tag = tag_in;
      i_start = 1'b1; i_sys_enable = 1'b1; i_data_valid = 1'b0;
      e = 0; blk_in = 0; pt_seen = 0; dis_cnt = 0; trig_ct = -1;
      done_seen = 0; aborted = 0; prev_en = 1; xfer = 0; freeze_pv = 0;
      while (!done_seen && !aborted && e < 400) begin
         @(negedge clock);
         i_start = 1'b0; i_nonce = n; i_last_bytes = 4'(lb);
         if (xfer && blk_in < NB + 1) blk_in++;
         if (prev_en) begin
            if (e == 0) begin
               check_eq({name, " tag_ok cleared"}, o_tag_ok, 0);
               check_eq({name, " ready in INIT"}, o_ready, 0);
            end
            if (o_valid_plain) begin
               if (pt_seen < NB)
                  check_eq($sformatf("%s plain%0d", name, pt_seen), o_plain, exp_pt[pt_seen]);
               else
                  check_eq({name, " extra plain"}, pt_seen < NB, 1);
               pt_seen++;
               if (mode == 1 && pt_seen == 1) trig_ct = e + 2;
               if (mode == 1 && pt_seen == 2) begin dis_cnt = 5; freeze_pv = 1; end
               if (mode == 3 && pt_seen == NB) begin
                  reset = 1'b1;
                  #1;
                  check_eq({name, " rst plain"}, o_plain, 0);
                  check_eq({name, " rst valid"}, o_valid_plain, 0);
                  check_eq({name, " rst ready"}, o_ready, 0);
                  check_eq({name, " rst done"}, o_done, 0);
                  check_eq({name, " rst tag_ok"}, o_tag_ok, 0);
                  aborted = 1;
                  i_data_valid = 1'b0;
               end
            end
            if (o_done) begin
               done_seen = 1;
               check_eq({name, " tag_ok"}, o_tag_ok, exp_ok);
               check_eq({name, " plain count"}, pt_seen, NB);
               if (exp_lat >= 0) check_eq({name, " latency"}, e, exp_lat);
            end
         end else begin
            check_eq({name, " frozen ready"}, o_ready, 0);
            check_eq({name, " frozen done"}, o_done, 0);
            check_eq({name, " frozen valid"}, o_valid_plain, freeze_pv);
            if (freeze_pv) check_eq({name, " frozen plain"}, o_plain, exp_pt[1]);
         end
         if (!aborted) begin
            if (mode == 1 && (e == 3 || e == trig_ct)) begin dis_cnt = 5; freeze_pv = 0; end
            en = (dis_cnt == 0);
            if (!en) dis_cnt--;
            i_sys_enable = en;
            if (o_ready) begin
               i_data = (blk_in == 0) ? ad : ct_blk[(blk_in > NB) ? NB - 1 : blk_in - 1];
               i_data_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            end else begin
               i_data = {$urandom, $urandom};
               i_data_valid = (mode == 2);
            end
            if (mode == 2 && e == 24) begin
               i_start = 1'b1;
               i_nonce = ~n;
               i_last_bytes = 4'((lb % 8) + 1);
            end
            xfer = o_ready && i_data_valid && en;
            prev_en = en;
            e++;
         end
      end
      if (aborted) begin
         @(negedge clock);
         reset = 1'b0;
         i_sys_enable = 1'b1;
         i_data_valid = 1'b1;
         repeat (3) begin
            @(negedge clock);
            check_eq({name, " idle after reset"}, o_ready, 0);
         end
         i_data_valid = 1'b0;
      end else if (!done_seen) begin
         check_eq({name, " done timeout"}, done_seen, 1);
      end else begin
         i_data_valid = 1'b0;
         @(negedge clock);
         check_eq({name, " tag_ok held"}, o_tag_ok, exp_ok);
         check_eq({name, " done pulse"}, o_done, 0);
      end
      i_data_valid = 1'b0;
      $display("msg %-12s lb=%0d blocks=%0d tag_ok=%0b edges=%0d", name, lb, pt_seen, o_tag_ok, e);
   endtask

   initial begin
      logic [127:0] k, n;
      logic [63:0]  ad;
      int           lb;
      bit           flip;
      reset = 1'b1; i_sys_enable = 1'b1; i_start = 1'b0; i_data_valid = 1'b0;
      i_data = '0; i_last_bytes = 4'd8; i_key = '0; i_nonce = '0; i_tag = '0;
      repeat (2) @(negedge clock);
      check_eq("reset ready", o_ready, 0);
      check_eq("reset plain", o_plain, 0);
      check_eq("reset valid", o_valid_plain, 0);
      check_eq("reset tag_ok", o_tag_ok, 0);
      check_eq("reset done", o_done, 0);
      reset = 1'b0;

      k  = 128'h000102030405060708090A0B0C0D0E0F;
      n  = 128'h000102030405060708090A0B0C0D0E0F;
      ad = 64'h3230323280000000;
      pt_blk[0] = 64'h1122334455667788;
      pt_blk[1] = 64'h99AABBCCDDEEFF00;
      pt_blk[2] = 64'h0123456789ABCD80;

      model_encrypt(k, n, ad, 8);
      run_msg("loopback", k, n, ad, 8, exp_tag, 1, 46, 0, 0);
      model_encrypt(k, n, ad, 8);
      run_msg("bad_tag", k, n, ad, 8, exp_tag ^ 128'd1, 0, 46, 0, 0);
      model_encrypt(k, n, ad, 3);
      run_msg("partial3", k, n, ad, 3, exp_tag, 1, 46, 0, 0);
      model_encrypt(k, n, ad, 8);
      run_msg("freeze", k, n, ad, 8, exp_tag, 1, 61, 1, 0);
      model_encrypt(k, n, ad, 8);
      run_msg("noise", k, n, ad, 8, exp_tag, 1, 46, 2, 0);
      model_encrypt(k, n, ad, 8);
      run_msg("reset_final", k, n, ad, 8, exp_tag, 1, -1, 3, 0);
      model_encrypt(k, n, ad, 8);
      run_msg("after_reset", k, n, ad, 8, exp_tag, 1, 46, 0, 0);

      for (int m = 0; m < 8; m++) begin
         k  = {$urandom, $urandom, $urandom, $urandom};
         n  = {$urandom, $urandom, $urandom, $urandom};
         ad = {$urandom, $urandom};
         lb = $urandom_range(1, 8);
         for (int j = 0; j < NB; j++) pt_blk[j] = {$urandom, $urandom};
         model_encrypt(k, n, ad, lb);
         flip = 1'($urandom_range(0, 1));
         run_msg($sformatf("rand%0d", m), k, n, ad, lb,
                 flip ? (exp_tag ^ (128'd1 << $urandom_range(0, 127))) : exp_tag,
                 !flip, -1, 0, 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
